// File: rtl/ps2_pkg.sv
// Shared PS/2 host-transmit types: FSM state encoding, timer width and device command bytes.
package ps2_pkg;

   localparam int unsigned TimerW = 17;

   localparam logic [7:0] CMD_SET_LEDS = 8'hED;
   localparam logic [7:0] CMD_ENABLE   = 8'hF4;
   localparam logic [7:0] CMD_RESET    = 8'hFF;

   typedef enum logic [2:0] {
      StIdle,
      StInhibit,
      StStart,
      StBits,
      StStop,
      StAck,
      StWaitIdle
   } ps2_state_e;

   // Odd parity: the parity bit makes the total count of ones odd.
   function automatic logic odd_parity(input logic [7:0] data);
      return ~(^data);
   endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for a raw PS/2 pad plus a falling-edge detector on the synchronized level.
module ps2_sync_edge (
   input  logic clock,
   input  logic resetn,
   input  logic in_i,
   output logic sync_o,
   output logic fall_o
);

   logic meta_q, sync_q, prev_q;

   // Reset to the idle-high line level so leaving reset never looks like an edge.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         prev_q <= 1'b1;
      end else begin
         meta_q <= in_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign sync_o = sync_q;
   assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter (open-drain clock/data).
// Define PS2_HOST_TX_TIMEOUT_EN to add a watchdog on the device clock during START..ACK.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 50000000,
   parameter int unsigned INHIBIT_US = 100,
   parameter int unsigned TIMEOUT_US = 2000
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_done,
   output logic       tx_err,
   input  logic       ps2c_in,
   input  logic       ps2d_in,
   output logic       ps2c_oe,
   output logic       ps2d_oe,
   output logic       rx_inhibit
);

   localparam int unsigned InhibitCycles = CLK_HZ / 1000000 * INHIBIT_US;
   localparam logic [TimerW-1:0] InhibitLast = TimerW'(InhibitCycles - 1);
`ifdef PS2_HOST_TX_TIMEOUT_EN
   localparam int unsigned TimeoutCycles = CLK_HZ / 1000000 * TIMEOUT_US;
   localparam logic [TimerW-1:0] TimeoutLast = TimerW'(TimeoutCycles - 1);
`endif

   ps2_state_e        state_q, state_d;
   logic [TimerW-1:0] timer_q, timer_d;
   logic [3:0]        bit_cnt_q, bit_cnt_d;
   logic [8:0]        shift_q, shift_d;
   logic              ack_ok_q, ack_ok_d;
   logic              tx_done_q, tx_done_d;
   logic              tx_err_q, tx_err_d;
   logic              c_sync, c_fall, d_sync, d_fall_unused;

   ps2_sync_edge u_sync_c (
      .clock  (clock),
      .resetn (resetn),
      .in_i   (ps2c_in),
      .sync_o (c_sync),
      .fall_o (c_fall)
   );

   ps2_sync_edge u_sync_d (
      .clock  (clock),
      .resetn (resetn),
      .in_i   (ps2d_in),
      .sync_o (d_sync),
      .fall_o (d_fall_unused)
   );

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      ack_ok_d  = ack_ok_q;
      tx_done_d = 1'b0;
      tx_err_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (tx_valid) begin
               shift_d   = {odd_parity(tx_data), tx_data};
               bit_cnt_d = '0;
               ack_ok_d  = 1'b0;
               state_d   = StInhibit;
            end
         end
         StInhibit: begin
            if (timer_q == InhibitLast) state_d = StStart;
         end
         StStart: begin
            if (c_fall) begin
               bit_cnt_d = 4'd1;
               state_d   = StBits;
            end
         end
         // Edge 1 put data bit 0 out; edges 2..9 shift so parity sits in bit 0 on entering STOP.
         StBits: begin
            if (c_fall) begin
               shift_d   = {1'b0, shift_q[8:1]};
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q == 4'd8) state_d = StStop;
            end
         end
         StStop: begin
            if (c_fall) begin
               bit_cnt_d = bit_cnt_q + 4'd1;
               state_d   = StAck;
            end
         end
         StAck: begin
            if (c_fall) begin
               ack_ok_d = ~d_sync;
               tx_err_d = d_sync;
               state_d  = StWaitIdle;
            end
         end
         StWaitIdle: begin
            if (c_sync && d_sync) begin
               tx_done_d = ack_ok_q;
               state_d   = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
`ifdef PS2_HOST_TX_TIMEOUT_EN
      if ((state_q inside {StStart, StBits, StStop, StAck}) && !c_fall && timer_q == TimeoutLast)
      begin
         state_d   = StIdle;
         ack_ok_d  = 1'b0;
         tx_done_d = 1'b0;
         tx_err_d  = 1'b1;
      end
`endif
   end

   // One timer: inhibit length in INHIBIT, device-clock watchdog in START..ACK when enabled.
   always_comb begin
      timer_d = timer_q + 1'b1;
      if (state_d != state_q) begin
         timer_d = '0;
`ifdef PS2_HOST_TX_TIMEOUT_EN
      end else if ((state_q inside {StIdle, StWaitIdle}) || (c_fall && state_q != StInhibit)) begin
`else
      end else if (state_q != StInhibit) begin
`endif
         timer_d = '0;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q   <= StIdle;
         timer_q   <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         ack_ok_q  <= 1'b0;
         tx_done_q <= 1'b0;
         tx_err_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         ack_ok_q  <= ack_ok_d;
         tx_done_q <= tx_done_d;
         tx_err_q  <= tx_err_d;
      end
   end

   always_comb begin
      ps2c_oe = 1'b0;
      ps2d_oe = 1'b0;
      unique case (state_q)
         StInhibit:      ps2c_oe = 1'b1;
         StStart:        ps2d_oe = 1'b1;
         StBits, StStop: ps2d_oe = ~shift_q[0];
         default:        ;
      endcase
   end

   assign tx_ready   = (state_q == StIdle);
   assign rx_inhibit = (state_q != StIdle);
   assign tx_done    = tx_done_q;
   assign tx_err     = tx_err_q;

endmodule
